fifo_word_packer: RTL

//   Drain stage directly downstream of fifo_mem. Pops bytes via rd / fifo_empty / data_out.

---
 rtl/fifo_word_packer_if.sv | 26 ++
 rtl/fifo_word_packer.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/fifo_word_packer_if.sv
// Word output port of fifo_word_packer: one packed word plus its valid-byte count.
// A word transfers on every rising clk edge where m_valid && m_ready; while m_valid is high and
// m_ready is low the master holds m_data and m_bytes stable and does not retract m_valid.
interface fifo_word_packer_if #(
  parameter int DATA_W         = 8,
  parameter int BYTES_PER_WORD = 4
);
  logic                             m_valid;
  logic                             m_ready;
  logic [DATA_W*BYTES_PER_WORD-1:0] m_data;
  logic [3:0]                       m_bytes;

  modport master (
    output m_valid,
    output m_data,
    output m_bytes,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_bytes,
    output m_ready
  );
endinterface

// File: rtl/fifo_word_packer.sv
// Drains bytes from fifo_mem and packs them, first byte in the low lane, into words on a
// valid/ready port. Partial words leave on flush or after FLUSH_TIMEOUT idle cycles.
module fifo_word_packer #(
  parameter int DATA_W         = 8,
  parameter int BYTES_PER_WORD = 4,
  parameter int FLUSH_TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd,
  input  logic              flush,
  fifo_word_packer_if.master m_if,
  output logic [1:0]        o_state
);

  localparam int              IDLE_W = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT + 1) : 1;
  localparam bit              TO_EN  = (FLUSH_TIMEOUT != 0);
  localparam logic [3:0]      BPW4   = 4'(BYTES_PER_WORD);
  localparam logic [IDLE_W-1:0] TO_LAST = IDLE_W'(FLUSH_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_CAPT = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  state_t                               r_state;
  state_t                               w_next;
  logic [3:0]                           r_cnt;
  logic [IDLE_W-1:0]                    r_idle_cnt;
  logic                                 r_flush_pend;
  logic [BYTES_PER_WORD-1:0][DATA_W-1:0] r_lanes;

  logic w_flush_eff;
  logic w_has_bytes;
  logic w_pop;
  logic w_idle_inc;
  logic w_send;

  assign w_flush_eff = flush | r_flush_pend;
  assign w_has_bytes = (r_cnt != 4'd0);
  assign w_send      = (r_state == ST_SEND);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_FILL;
    end else begin
      r_state <= w_next;
    end
  end

  // Flush outranks a pop in FILL; CAPT always returns to FILL or SEND, so pops are never adjacent.
  always_comb begin
    w_next     = r_state;
    w_pop      = 1'b0;
    w_idle_inc = 1'b0;
    unique case (r_state)
      ST_FILL: begin
        if (w_flush_eff && w_has_bytes) begin
          w_next = ST_SEND;
        end else if (!fifo_empty && (r_cnt < BPW4)) begin
          w_pop  = 1'b1;
          w_next = ST_CAPT;
        end else if (TO_EN && w_has_bytes && fifo_empty) begin
          w_idle_inc = 1'b1;
          if (r_idle_cnt == TO_LAST) begin
            w_next = ST_SEND;
          end
        end
      end
      ST_CAPT: begin
        if (((r_cnt + 4'd1) == BPW4) || w_flush_eff) begin
          w_next = ST_SEND;
        end else begin
          w_next = ST_FILL;
        end
      end
      ST_SEND: begin
        if (m_if.m_ready) begin
          w_next = ST_FILL;
        end
      end
      default: begin
        w_next = ST_FILL;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt        <= 4'd0;
      r_idle_cnt   <= '0;
      r_flush_pend <= 1'b0;
      r_lanes      <= '0;
    end else begin
      unique case (r_state)
        ST_FILL: begin
          if (!w_has_bytes) begin
            r_flush_pend <= 1'b0;
          end
          if (w_idle_inc) begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
          end
        end
        ST_CAPT: begin
          for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (r_cnt == 4'(i)) begin
              r_lanes[i] <= fifo_data;
            end
          end
          if (r_cnt < BPW4) begin
            r_cnt <= r_cnt + 4'd1;
          end
          r_idle_cnt <= '0;
          if (flush) begin
            r_flush_pend <= 1'b1;
          end
        end
        ST_SEND: begin
          if (m_if.m_ready) begin
            r_cnt        <= 4'd0;
            r_idle_cnt   <= '0;
            r_flush_pend <= 1'b0;
            r_lanes      <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // The pop strobe is combinational, so reset must mask it to keep fifo_mem untouched.
  assign fifo_rd      = w_pop & ~rst;
  assign m_if.m_valid = w_send;
  assign m_if.m_data  = w_send ? r_lanes : '0;
  assign m_if.m_bytes = w_send ? r_cnt : 4'd0;
  assign o_state      = r_state;

endmodule
